apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_pkg.sv | 20 ++
 rtl/apb_master_tmo.sv | 47 ++++
 rtl/apb_master.sv | 160 ++++++++++++++++
 tb/tb_apb_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default constants for the APB master slice.
// State encoding and bus field widths live here so the top and the timeout block agree.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned DEF_RW  = 32;
    localparam int unsigned DEF_RAW = 5;
    localparam int unsigned DEF_TW  = 8;
    localparam int unsigned DEF_TMO = 255;

    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;

endpackage

// File: rtl/apb_master_tmo.sv
// ACCESS-phase watchdog: counts cycles spent waiting on pready and flags expiry.
// The counter saturates so a disabled or very long wait can never wrap back to zero.
module apb_master_tmo
    import apb_master_pkg::*;
#(
    parameter int unsigned TW  = DEF_TW,
    parameter int unsigned TMO = DEF_TMO
) (
    input  logic apb_pclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);
    // The count holds completed ACCESS cycles, so expiry fires during cycle number TMO.
    localparam logic [TW-1:0] TMO_LAST = (TMO == 0) ? {TW{1'b0}} : TW'(TMO - 32'd1);
    localparam logic          TMO_EN   = (TMO != 0) ? 1'b1 : 1'b0;

    logic [TW-1:0] cnt_r;

    // Saturating ACCESS-cycle counter, cleared whenever the master is not waiting.
    always_ff @(posedge apb_pclk) begin
        if (reset) begin
            cnt_r <= {TW{1'b0}};
        end else if (clear) begin
            cnt_r <= {TW{1'b0}};
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry decode taken straight from the registered count.
    always_comb begin
        expire = 1'b0;
        if (TMO_EN && enable && (cnt_r >= TMO_LAST)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one request, runs SETUP/ACCESS on the bus,
// then holds the response until the requester takes it. All outputs are registered.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned RW  = DEF_RW,
    parameter int unsigned RAW = DEF_RAW,
    parameter int unsigned TW  = DEF_TW,
    parameter int unsigned TMO = DEF_TMO
) (
    input  logic             apb_pclk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [RAW-1:0]   req_addr,
    input  logic [RW-1:0]    req_wdata,
    input  logic [3:0]       req_strb,
    input  logic [2:0]       req_prot,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic [RAW-1:0]   apb_paddr,
    output logic             apb_pwrite,
    output logic [RW-1:0]    apb_pwdata,
    output logic [3:0]       apb_pstrb,
    output logic [2:0]       apb_pprot,
    output logic             apb_psel,
    output logic             apb_penable,
    input  logic             apb_pready,
    input  logic [RW-1:0]    apb_prdata,
    input  logic             apb_pslverr
);

    apb_state_e      state_r;
    logic            req_ready_r;
    logic            psel_r;
    logic            penable_r;
    logic [RAW-1:0]  paddr_r;
    logic            pwrite_r;
    logic [RW-1:0]   pwdata_r;
    logic [3:0]      pstrb_r;
    logic [2:0]      pprot_r;
    logic            rsp_valid_r;
    logic [RW-1:0]   rsp_rdata_r;
    logic            rsp_err_r;

    logic            tmo_clear_s;
    logic            tmo_enable_s;
    logic            tmo_expire_s;

    assign tmo_enable_s = (state_r == ST_ACCESS) ? 1'b1 : 1'b0;
    assign tmo_clear_s  = ~tmo_enable_s;

    apb_master_tmo #(
        .TW  (TW),
        .TMO (TMO)
    ) u_tmo (
        .apb_pclk (apb_pclk),
        .reset    (reset),
        .clear    (tmo_clear_s),
        .enable   (tmo_enable_s),
        .expire   (tmo_expire_s)
    );

    // Transfer sequencer with registered bus and response outputs.
    always_ff @(posedge apb_pclk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            paddr_r     <= {RAW{1'b0}};
            pwrite_r    <= 1'b0;
            pwdata_r    <= {RW{1'b0}};
            pstrb_r     <= 4'h0;
            pprot_r     <= 3'h0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {RW{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        paddr_r     <= req_addr;
                        pwrite_r    <= req_write;
                        pwdata_r    <= req_wdata;
                        pstrb_r     <= req_strb;
                        pprot_r     <= req_prot;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_SETUP;
                    end else begin
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A completing slave wins over a watchdog expiring in the same cycle.
                    if (apb_pready || tmo_expire_s) begin
                        if (apb_pready) begin
                            rsp_rdata_r <= pwrite_r ? {RW{1'b0}} : apb_prdata;
                            rsp_err_r   <= apb_pslverr;
                        end else begin
                            rsp_rdata_r <= {RW{1'b0}};
                            rsp_err_r   <= 1'b1;
                        end
                        rsp_valid_r <= 1'b1;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        paddr_r     <= {RAW{1'b0}};
                        pwrite_r    <= 1'b0;
                        pwdata_r    <= {RW{1'b0}};
                        pstrb_r     <= 4'h0;
                        pprot_r     <= 3'h0;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    // Returning through IDLE keeps req_ready low in the completing cycle.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign apb_paddr   = paddr_r;
    assign apb_pwrite  = pwrite_r;
    assign apb_pwdata  = pwdata_r;
    assign apb_pstrb   = pstrb_r;
    assign apb_pprot   = pprot_r;
    assign apb_psel    = psel_r;
    assign apb_penable = penable_r;

endmodule

// File: tb/tb_apb_master.sv
// Randomised scoreboard bench for apb_master against a 32x32 register slave model.
// Expected responses and bus phases are queued at issue time and popped by a monitor.
module tb_apb_master;

    localparam int RW    = 32;
    localparam int RAW   = 5;
    localparam int TW    = 8;
    localparam int TMO_T = 4;

    logic            apb_pclk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [RAW-1:0]  req_addr;
    logic [RW-1:0]   req_wdata;
    logic [3:0]      req_strb;
    logic [2:0]      req_prot;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [RW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [RAW-1:0]  apb_paddr;
    logic            apb_pwrite;
    logic [RW-1:0]   apb_pwdata;
    logic [3:0]      apb_pstrb;
    logic [2:0]      apb_pprot;
    logic            apb_psel;
    logic            apb_penable;
    logic            apb_pready = 1'b0;
    logic [RW-1:0]   apb_prdata = 32'h0;
    logic            apb_pslverr = 1'b0;

    apb_master #(.RW(RW), .RAW(RAW), .TW(TW), .TMO(TMO_T)) dut (
        .apb_pclk(apb_pclk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
        .apb_pstrb(apb_pstrb), .apb_pprot(apb_pprot), .apb_psel(apb_psel),
        .apb_penable(apb_penable), .apb_pready(apb_pready), .apb_prdata(apb_prdata),
        .apb_pslverr(apb_pslverr)
    );

    always #5 apb_pclk = ~apb_pclk;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct {
        logic [4:0] addr; logic write; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
        int pen; int lat;
    } bus_t;
    typedef struct { int w; logic e; } plan_t;

    exp_t  exp_q[$];
    bus_t  bus_q[$];
    plan_t plan_q[$];
    logic [31:0] ref_mem [32];
    logic [31:0] smem [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_token = 0;

    always @(posedge apb_pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Register slave: wait states and error come from the plan queued with each request.
    int    scnt = 0;
    plan_t scur;
    always @(posedge apb_pclk) begin
        #1;
        if (reset) begin
            apb_pready = 1'b0; apb_prdata = 32'h0; apb_pslverr = 1'b0; scnt = 0;
        end else if (apb_psel && !apb_penable) begin
            scnt = 0;
            apb_pready = 1'b0;
            if (plan_q.size() > 0) begin
                scur = plan_q.pop_front();
            end else begin
                scur.w = 0; scur.e = 1'b0;
                checks++; errors++;
                $display("FAIL slave_plan actual=empty required=queued");
            end
        end else if (apb_psel && apb_penable) begin
            scnt++;
            if (scnt == scur.w + 1) begin
                apb_pready  = 1'b1;
                apb_prdata  = smem[apb_paddr];
                apb_pslverr = scur.e;
                if (apb_pwrite && !scur.e)
                    for (int b = 0; b < 4; b++)
                        if (apb_pstrb[b]) smem[apb_paddr][8*b +: 8] = apb_pwdata[8*b +: 8];
            end else begin
                apb_pready  = 1'b0;
                apb_prdata  = $urandom;
                apb_pslverr = 1'($urandom_range(0, 1));
            end
        end else begin
            apb_pready = 1'b0; apb_prdata = 32'h0; apb_pslverr = 1'b0;
        end
    end

    // Response consumer: random backpressure, or a forced 5-cycle stall when requested.
    int tok_seen = 0;
    int stall_left = 0;
    always @(posedge apb_pclk) begin
        #1;
        if (stall_token != tok_seen) begin
            tok_seen = stall_token;
            stall_left = 5;
        end
        if (stall_left > 0) begin
            rsp_ready = 1'b0;
            if (rsp_valid) stall_left--;
        end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: bus-phase scoreboard, protocol rules and response scoreboard.
    int   acc_cyc = 0;
    int   pen_cnt = 0;
    logic rv_prev = 1'b0;
    bus_t cur;
    exp_t ex;
    always @(negedge apb_pclk) begin
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            chk("penable_without_psel", {63'h0, apb_penable & ~apb_psel}, 64'h0);
            if (req_valid && req_ready) acc_cyc = cyc;
            if (apb_psel && !apb_penable) begin
                chk("setup_latency", cyc - acc_cyc, 1);
                pen_cnt = 0;
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_phase actual=unexpected_setup required=none");
                end else begin
                    cur = bus_q.pop_front();
                    chk("setup_paddr", apb_paddr, cur.addr);
                    chk("setup_pwrite", apb_pwrite, cur.write);
                    chk("setup_pwdata", apb_pwdata, cur.wdata);
                    chk("setup_pstrb", apb_pstrb, cur.strb);
                    chk("setup_pprot", apb_pprot, cur.prot);
                end
            end
            if (apb_penable) begin
                pen_cnt++;
                chk("hold_paddr", apb_paddr, cur.addr);
                chk("hold_pwdata", apb_pwdata, cur.wdata);
                chk("hold_ctrl", {apb_pwrite, apb_pstrb, apb_pprot}, {cur.write, cur.strb, cur.prot});
            end
            if (rsp_valid && !rv_prev) begin
                chk("rsp_latency", cyc - acc_cyc, cur.lat);
                chk("penable_cycles", pen_cnt, cur.pen);
                chk("bus_idle_in_resp", {apb_psel, apb_penable}, 2'b00);
            end
            if (rsp_valid) begin
                chk("req_ready_while_resp", req_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected actual=valid required=none");
                end else begin
                    ex = exp_q[0];
                    chk("rsp_rdata", rsp_rdata, ex.rdata);
                    chk("rsp_err", rsp_err, ex.err);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            rv_prev = rsp_valid;
        end
    end

    // Issue one request; expectations come from the reference memory and the slave plan.
    task automatic do_req(input logic wr, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input int w, input logic e);
        exp_t x; bus_t b; plan_t pl; int n;
        pl.w = w; pl.e = e;
        b.addr = a; b.write = wr; b.wdata = d; b.strb = s; b.prot = p;
        if (w >= TMO_T) begin
            x.rdata = 32'h0; x.err = 1'b1; b.pen = TMO_T; b.lat = 2 + TMO_T;
        end else begin
            x.err = e;
            x.rdata = wr ? 32'h0 : ref_mem[a];
            b.pen = w + 1; b.lat = 3 + w;
            if (wr && !e)
                for (int k = 0; k < 4; k++)
                    if (s[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
        end
        exp_q.push_back(x); bus_q.push_back(b); plan_q.push_back(pl);
        @(posedge apb_pclk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
        n = 0;
        @(negedge apb_pclk);
        while (!req_ready && n < 200) begin @(negedge apb_pclk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_accept actual=not_ready required=accepted");
        end
        @(posedge apb_pclk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1)); req_addr = 5'($urandom); req_wdata = $urandom;
        req_strb = 4'($urandom); req_prot = 3'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin @(negedge apb_pclk); n++; end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin ref_mem[i] = 32'h0; smem[i] = 32'h0; end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 5'h0;
        req_wdata = 32'h0; req_strb = 4'h0; req_prot = 3'h0;
        repeat (3) @(posedge apb_pclk);
        @(negedge apb_pclk);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_bus_ctrl", {apb_psel, apb_penable, apb_pwrite}, 3'b000);
        chk("reset_rsp", {rsp_valid, rsp_err}, 2'b00);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_bus_data", {apb_paddr, apb_pwdata, apb_pstrb, apb_pprot}, 44'h0);
        @(posedge apb_pclk); #1; reset = 1'b0;

        do_req(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0);
        do_req(1'b0, 5'd5, 32'h0, 4'hF, 3'd1, 3, 1'b0);
        do_req(1'b0, 5'd7, 32'h0, 4'hF, 3'd2, 99, 1'b0);
        wait_drain();
        stall_token++;
        do_req(1'b1, 5'd9, 32'h12345678, 4'hF, 3'd3, 0, 1'b1);
        do_req(1'b1, 5'd31, 32'h1, 4'hF, 3'd0, 0, 1'b0);
        do_req(1'b0, 5'd31, 32'h0, 4'hF, 3'd0, 0, 1'b0);

        for (int t = 0; t < 60; t++)
            do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                   4'($urandom), 3'($urandom), $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
        wait_drain();

        // Reset during ACCESS: the in-flight read must vanish without a response.
        do_req(1'b0, 5'd3, 32'h0, 4'hF, 3'd0, 3, 1'b0);
        n = 0;
        @(negedge apb_pclk);
        while (!apb_penable && n < 10) begin @(negedge apb_pclk); n++; end
        chk("reached_access", apb_penable, 1'b1);
        reset = 1'b1;
        @(negedge apb_pclk);
        chk("midreset_bus", {apb_psel, apb_penable}, 2'b00);
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        chk("midreset_req_ready", req_ready, 1'b1);
        exp_q.delete(); bus_q.delete(); plan_q.delete();
        @(posedge apb_pclk); #1; reset = 1'b0;

        do_req(1'b1, 5'd12, 32'hA5A5_0F0F, 4'h5, 3'd4, 1, 1'b0);
        do_req(1'b0, 5'd12, 32'h0, 4'hF, 3'd0, 2, 1'b0);
        wait_drain();
        repeat (3) @(posedge apb_pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
